// File: rtl/serial_frame_ctrl.sv
// -----------------------------------------------------------------------------
// serial_frame_ctrl
//
// Sequencer for the serial-in / RAM / serial-out datapath. In load mode it
// writes words arriving from the deserializer into consecutive RAM addresses.
// On a send request it reads the stored frame back in order and hands each
// word to the serializer with a start/busy handshake.
//
// Optional build macro:
//   LOOP_SEND_EN - when defined, holding send high retransmits the stored frame
//                  continuously. Dropping send finishes the current pass and
//                  then returns to idle.
//
// Parameters:
//   ADDR_W - RAM address width. The frame holds up to 2^ADDR_W words.
//   DATA_W - word width.
//   RD_LAT - RAM read latency in clock cycles (1..3).
//
// Ports:
//   sysclk_i       system clock; all logic runs on the rising edge
//   reset_i        synchronous reset, active low
//   write_i        level; high requests load mode
//   send_i         level; a rising edge requests transmission of the frame
//   rx_valid_i     one-cycle strobe: rx_word_i holds a complete word
//   rx_word_i      word from the deserializer
//   ram_we_o       RAM write enable
//   ram_addr_o     RAM address
//   ram_wdata_o    RAM write data
//   ram_rdata_i    RAM read data, valid RD_LAT cycles after ram_addr_o
//   tx_data_o      word to the serializer, held stable during transmission
//   tx_start_o     one-cycle start pulse to the serializer
//   tx_busy_i      serializer busy
//   word_count_o   number of words stored (0..2^ADDR_W)
//   overflow_o     sticky: a word arrived while the RAM was full
//   done_o         one-cycle pulse after the last word has been transmitted
//   active_o       high in every state except idle
// -----------------------------------------------------------------------------
module serial_frame_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              sysclk_i,
  input  logic              reset_i,
  input  logic              write_i,
  input  logic              send_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_word_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  output logic [ADDR_W:0]   word_count_o,
  output logic              overflow_o,
  output logic              done_o,
  output logic              active_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD_WAIT,
    S_TX_START,
    S_TX_WAIT,
    S_DONE
  } state_e;

  // Word counts carry one extra bit so that a completely full RAM
  // (2^ADDR_W words) is representable.
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
  // RD_WAIT lasts RD_LAT+1 cycles: one cycle for the address register to
  // reach the RAM, then RD_LAT cycles of read latency.
  localparam logic [1:0]      LAT_LAST = 2'(RD_LAT);

  state_e              state_q;
  logic                send_q;
  logic [ADDR_W:0]     wr_ptr_q;
  logic [ADDR_W:0]     rd_ptr_q;
  logic [ADDR_W:0]     word_count_q;
  logic [1:0]          lat_cnt_q;
  logic                busy_seen_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                ram_we_q;
  logic                tx_start_q;
  logic                done_q;
  logic                overflow_q;
  logic                active_q;

  logic                send_edge;
  logic                full;
  logic [ADDR_W:0]     rd_ptr_inc;

  assign send_edge  = send_i & ~send_q;
  assign full       = (wr_ptr_q == CAPACITY);
  assign rd_ptr_inc = rd_ptr_q + ONE;

  always_ff @(posedge sysclk_i) begin
    if (!reset_i) begin
      state_q      <= S_IDLE;
      send_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      word_count_q <= '0;
      lat_cnt_q    <= '0;
      busy_seen_q  <= 1'b0;
      tx_data_q    <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      tx_start_q   <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      send_q     <= send_i;
      // Single-cycle strobes fall back to zero unless re-asserted below.
      ram_we_q   <= 1'b0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          // write has priority; a simultaneous send edge is discarded.
          if (write_i) begin
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            active_q     <= 1'b1;
          end else if (send_edge && (word_count_q != '0)) begin
            state_q    <= S_RD_WAIT;
            rd_ptr_q   <= '0;
            ram_addr_q <= '0;
            lat_cnt_q  <= '0;
            active_q   <= 1'b1;
          end
        end

        S_LOAD: begin
          // A strobe in the same cycle that write drops is still stored.
          if (rx_valid_i) begin
            if (!full) begin
              ram_we_q     <= 1'b1;
              ram_addr_q   <= wr_ptr_q[ADDR_W-1:0];
              ram_wdata_q  <= rx_word_i;
              wr_ptr_q     <= wr_ptr_q + ONE;
              word_count_q <= word_count_q + ONE;
            end else begin
              overflow_q <= 1'b1;
            end
          end
          if (!write_i) begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
          end
        end

        S_RD_WAIT: begin
          if (lat_cnt_q == LAT_LAST) begin
            tx_data_q  <= ram_rdata_i;
            tx_start_q <= 1'b1;
            state_q    <= S_TX_START;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end

        S_TX_START: begin
          busy_seen_q <= 1'b0;
          state_q     <= S_TX_WAIT;
        end

        S_TX_WAIT: begin
          // Completion is the falling edge of busy after it has been seen
          // high, so a serializer that is slow to raise busy is not mistaken
          // for one that has already finished.
          if (tx_busy_i) begin
            busy_seen_q <= 1'b1;
          end else if (busy_seen_q) begin
            if (rd_ptr_inc == word_count_q) begin
              // rd_ptr stays on the last word; it is reloaded on the next send.
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rd_ptr_q   <= rd_ptr_inc;
              ram_addr_q <= rd_ptr_inc[ADDR_W-1:0];
              lat_cnt_q  <= '0;
              state_q    <= S_RD_WAIT;
            end
          end
        end

        S_DONE: begin
`ifdef LOOP_SEND_EN
          if (send_i) begin
            state_q    <= S_RD_WAIT;
            rd_ptr_q   <= '0;
            ram_addr_q <= '0;
            lat_cnt_q  <= '0;
          end else begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
          end
`else
          state_q  <= S_IDLE;
          active_q <= 1'b0;
`endif
        end

        default: begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign tx_data_o    = tx_data_q;
  assign tx_start_o   = tx_start_q;
  assign word_count_o = word_count_q;
  assign overflow_o   = overflow_q;
  assign done_o       = done_q;
  assign active_o     = active_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_ctrl
//
// Directed bench for serial_frame_ctrl with a behavioural 256x16 RAM
// (one-cycle read latency) and a serializer model that holds busy for
// BUSY_LEN cycles after each start pulse.
// -----------------------------------------------------------------------------
module tb_serial_frame_ctrl;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 1;
  localparam int BUSY_LEN = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              write;
  logic              send;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_word;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [ADDR_W:0]   word_count;
  logic              overflow;
  logic              done;
  logic              active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .sysclk_i    (clk),
    .reset_i     (reset),
    .write_i     (write),
    .send_i      (send),
    .rx_valid_i  (rx_valid),
    .rx_word_i   (rx_word),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .tx_data_o   (tx_data),
    .tx_start_o  (tx_start),
    .tx_busy_i   (tx_busy),
    .word_count_o(word_count),
    .overflow_o  (overflow),
    .done_o      (done),
    .active_o    (active)
  );

  // RAM model: synchronous write, registered read (latency 1).
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Serializer model: busy rises the cycle after tx_start, stays high BUSY_LEN cycles.
  int bcnt = 0;
  initial tx_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start) begin
      tx_busy <= 1'b1;
      bcnt    <= BUSY_LEN;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) tx_busy <= 1'b0;
    end
  end

  // Event logs, sampled on the falling edge.
  logic [ADDR_W+DATA_W-1:0] we_q[$];
  logic [DATA_W-1:0]        tx_q[$];
  int                       txc_q[$];
  int                       done_cnt   = 0;
  int                       done_cyc   = 0;
  int                       active_cnt = 0;

  always @(negedge clk) begin
    if (ram_we === 1'b1) we_q.push_back({ram_addr, ram_wdata});
    if (tx_start === 1'b1) begin
      tx_q.push_back(tx_data);
      txc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (active === 1'b1) active_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_logs();
    we_q.delete();
    tx_q.delete();
    txc_q.delete();
    done_cnt   = 0;
    active_cnt = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ram_we"},     32'(ram_we),     0);
    check({tag, "_ram_addr"},   32'(ram_addr),   0);
    check({tag, "_ram_wdata"},  32'(ram_wdata),  0);
    check({tag, "_tx_data"},    32'(tx_data),    0);
    check({tag, "_tx_start"},   32'(tx_start),   0);
    check({tag, "_word_count"}, 32'(word_count), 0);
    check({tag, "_overflow"},   32'(overflow),   0);
    check({tag, "_done"},       32'(done),       0);
    check({tag, "_active"},     32'(active),     0);
  endtask

  // One-cycle rx strobe followed by one idle cycle.
  task automatic strobe(input logic [DATA_W-1:0] w);
    rx_valid = 1'b1;
    rx_word  = w;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int errs;
    logic [ADDR_W+DATA_W-1:0] exp_we;

    reset    = 1'b0;
    write    = 1'b0;
    send     = 1'b0;
    rx_valid = 1'b0;
    rx_word  = '0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // ---- send edge with an empty frame is ignored ----
    clear_logs();
    send = 1'b1;
    repeat (10) @(posedge clk);
    #1 send = 1'b0;
    @(negedge clk);
    check("empty_send_tx_starts", tx_q.size(), 0);
    check("empty_send_active_cycles", active_cnt, 0);

    // ---- basic load; third strobe coincides with write dropping ----
    @(posedge clk); #1;
    clear_logs();
    write = 1'b1;
    @(posedge clk); #1;
    strobe(16'h1111);
    strobe(16'h2222);
    rx_valid = 1'b1;
    rx_word  = 16'h3333;
    write    = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("load_write_count", we_q.size(), 3);
    check("load_we0", (we_q.size() > 0) ? 32'(we_q[0]) : 32'hdead_beef, 32'h00_1111);
    check("load_we1", (we_q.size() > 1) ? 32'(we_q[1]) : 32'hdead_beef, 32'h01_2222);
    check("load_we2", (we_q.size() > 2) ? 32'(we_q[2]) : 32'hdead_beef, 32'h02_3333);
    check("load_word_count", 32'(word_count), 3);
    check("load_overflow", 32'(overflow), 0);
    check("load_back_idle", 32'(active), 0);

    // ---- send the 3-word frame ----
    @(posedge clk); #1;
    clear_logs();
    send = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 400; i++) begin
      if (done_cnt >= 1) break;
      @(posedge clk);
    end
    check("send_done_seen", 32'(done_cnt >= 1), 1);
    check("send_tx_count", tx_q.size(), 3);
    check("send_tx0", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hdead_beef, 32'h1111);
    check("send_tx1", (tx_q.size() > 1) ? 32'(tx_q[1]) : 32'hdead_beef, 32'h2222);
    check("send_tx2", (tx_q.size() > 2) ? 32'(tx_q[2]) : 32'hdead_beef, 32'h3333);
    // Edge to first start: RD_LAT+2 = 3 cycles.
    check("send_first_latency", (txc_q.size() > 0) ? txc_q[0] - t0 : -1, 3);
    // Start to start: 1 (busy rise) + 20 (busy) + 3 (gap RD_LAT+2) = 24.
    check("send_spacing01", (txc_q.size() > 1) ? txc_q[1] - txc_q[0] : -1, 24);
    check("send_spacing12", (txc_q.size() > 2) ? txc_q[2] - txc_q[1] : -1, 24);
    // Last start to done: 1 + 20 + 1 = 22.
    check("send_done_time", (txc_q.size() > 2) ? done_cyc - txc_q[2] : -1, 22);

    // send still held high after done
    repeat (60) @(posedge clk);
    @(negedge clk);
`ifdef LOOP_SEND_EN
    check("loop_tx3", (tx_q.size() > 4) ? 32'(tx_q[3]) : 32'hdead_beef, 32'h1111);
    check("loop_tx4", (tx_q.size() > 4) ? 32'(tx_q[4]) : 32'hdead_beef, 32'h2222);
    @(posedge clk); #1;
    send = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (active == 1'b0) break;
    end
    check("loop_stopped", 32'(active), 0);
    check("loop_whole_passes", tx_q.size() % 3, 0);
    check("loop_done_per_pass", done_cnt, tx_q.size() / 3);
`else
    check("hold_no_second_frame", tx_q.size(), 3);
    check("hold_single_done", done_cnt, 1);
    @(posedge clk); #1;
    send = 1'b0;
`endif
    check("send_word_count_kept", 32'(word_count), 3);

    // ---- write and send edge together: write wins ----
    repeat (2) @(posedge clk); #1;
    clear_logs();
    write = 1'b1;
    send  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("conflict_in_load", 32'(active), 1);
    check("conflict_count_cleared", 32'(word_count), 0);
    @(posedge clk); #1;
    write = 1'b0;
    send  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("conflict_no_tx", tx_q.size(), 0);
    check("conflict_idle", 32'(active), 0);

    // ---- overflow: 257 words into a 256-word RAM ----
    @(posedge clk); #1;
    clear_logs();
    write = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) strobe(16'(16'hA000 + i));
    @(negedge clk);
    check("full_word_count", 32'(word_count), 256);
    check("full_no_overflow_yet", 32'(overflow), 0);
    @(posedge clk); #1;
    strobe(16'hBEEF);
    write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ovf_write_count", we_q.size(), 256);
    errs = 0;
    for (int i = 0; i < 256 && i < we_q.size(); i++) begin
      exp_we = {8'(i), 16'(16'hA000 + i)};
      if (we_q[i] !== exp_we) errs++;
    end
    check("ovf_write_contents", errs, 0);
    check("ovf_last_write", (we_q.size() > 255) ? 32'(we_q[255]) : 32'hdead_beef, 32'hFF_A0FF);
    check("ovf_word_count", 32'(word_count), 256);
    check("ovf_overflow", 32'(overflow), 1);

    // ---- reset during TX_WAIT of the second word ----
    @(posedge clk); #1;
    clear_logs();
    send = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (tx_q.size() >= 2) break;
      @(posedge clk);
    end
    check("rst_reached_word2", 32'(tx_q.size() >= 2), 1);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    send  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_no_extra_start", tx_q.size(), 2);
    repeat (30) @(posedge clk); #1;
    clear_logs();
    send = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("postrst_no_tx", tx_q.size(), 0);
    check("postrst_no_active", active_cnt, 0);
    check("postrst_word_count", 32'(word_count), 0);
    send = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
